hazard_ctrl_gen: RTL and testbench

//  Parametrised hazard controller for the 5-stage core (IF/ID/EX/MEM/WB). Sits beside the pipeline registers.

---
 rtl/hazard_ctrl_gen.sv | 208 ++++++++++++++++++++
 tb/tb_hazard_ctrl_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_gen.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use and MDU scoreboard stalls,
// data-memory freeze, MEM-stage branch flushes, PC select and saturating stall/flush counters.
module hazard_ctrl_gen #(
    parameter int REG_AW    = 5,
    parameter int LU_STALL  = 1,
    parameter int WB_FWD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic              id_use_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic              id_reg_write_i,
    input  logic              id_is_mdu_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_is_nop_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_is_nop_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic              wb_reg_write_i,
    input  logic              mdu_issue_i,
    input  logic [REG_AW-1:0] mdu_issue_rd_i,
    input  logic              mdu_done_i,
    input  logic [REG_AW-1:0] mdu_done_rd_i,
    input  logic              mdu_busy_i,
    input  logic              dmem_stall_i,
    input  logic              branch_req_mem_i,
    input  logic [1:0]        pc_sel_mem_i,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              id_ex_stall_o,
    output logic              ex_mem_stall_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_flush_o,
    output logic              mem_wb_flush_o,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic [1:0]        pc_sel_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [1:0] PC_SEL_PC_PLUS_4 = 2'b00;
    localparam int NREG  = 2 ** REG_AW;
    localparam int LU_CW = (LU_STALL > 1) ? $clog2(LU_STALL) : 1;
    localparam logic [LU_CW-1:0] LU_INIT = LU_CW'(LU_STALL - 1);

    typedef enum logic {
        IDLE,
        LU_WAIT
    } lu_state_t;

    lu_state_t         state;
    logic [LU_CW-1:0]  lu_cnt;
    logic [NREG-1:0]   sb;
    logic              ex_fwd_ok;
    logic              mem_fwd_ok;
    logic              wb_fwd_ok;
    logic              lu_hit;
    logic              lu_active;
    logic              sb_hit;
    logic              any_flush;

    // Youngest producer wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic              reads,
        input logic [REG_AW-1:0] addr,
        input logic [REG_AW-1:0] ex_rd,
        input logic              ex_ok,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_ok,
        input logic [REG_AW-1:0] wb_rd,
        input logic              wb_ok
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (reads && addr != '0) begin
            if (ex_ok && ex_rd == addr)
                sel = 2'b01;
            else if (mem_ok && mem_rd == addr)
                sel = 2'b10;
            else if (wb_ok && wb_rd == addr)
                sel = 2'b11;
        end
        return sel;
    endfunction

    assign ex_fwd_ok  = ex_reg_write_i & ~ex_is_nop_i;
    assign mem_fwd_ok = mem_reg_write_i & ~mem_is_nop_i;
    assign wb_fwd_ok  = (WB_FWD_EN != 0) & wb_reg_write_i;

    assign lu_hit = ex_mem_read_i & ex_fwd_ok & (ex_rd_addr_i != '0) &
                    ((id_use_rs1_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                     (id_use_rs2_i & (id_rs2_addr_i == ex_rd_addr_i)));
    assign lu_active = lu_hit | (state == LU_WAIT);

    assign sb_hit = (id_use_rs1_i & sb[id_rs1_addr_i]) |
                    (id_use_rs2_i & sb[id_rs2_addr_i]) |
                    (id_reg_write_i & sb[id_rd_addr_i]) |
                    (id_is_mdu_i & mdu_busy_i);

    // Control priority: memory freeze, then branch flush, then hazard bubbles.
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        forward_a_o    = 2'b00;
        forward_b_o    = 2'b00;
        pc_sel_o       = PC_SEL_PC_PLUS_4;
        if (!rst) begin
            forward_a_o = fwd_sel(id_use_rs1_i, id_rs1_addr_i, ex_rd_addr_i, ex_fwd_ok,
                                  mem_rd_addr_i, mem_fwd_ok, wb_rd_addr_i, wb_fwd_ok);
            forward_b_o = fwd_sel(id_use_rs2_i, id_rs2_addr_i, ex_rd_addr_i, ex_fwd_ok,
                                  mem_rd_addr_i, mem_fwd_ok, wb_rd_addr_i, wb_fwd_ok);
            if (dmem_stall_i) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
                mem_wb_flush_o = 1'b1;
            end else if (branch_req_mem_i) begin
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                pc_sel_o       = pc_sel_mem_i;
            end else if (sb_hit || lu_active) begin
                pc_stall_o    = 1'b1;
                if_id_stall_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end
        end
    end

    // Load-use wait: the first bubble comes from detection in IDLE, the rest are counted here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lu_cnt <= '0;
        end else if (!dmem_stall_i) begin
            if (branch_req_mem_i) begin
                state  <= IDLE;
                lu_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (lu_hit && LU_STALL > 1) begin
                            state  <= LU_WAIT;
                            lu_cnt <= LU_INIT;
                        end
                    end
                    LU_WAIT: begin
                        if (lu_cnt == LU_CW'(1)) begin
                            state  <= IDLE;
                            lu_cnt <= '0;
                        end else begin
                            lu_cnt <= lu_cnt - LU_CW'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        lu_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Issue beats completion when both name the same register in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (mdu_issue_i && mdu_issue_rd_i != '0 && mdu_issue_rd_i == REG_AW'(i))
                    sb[i] <= 1'b1;
                else if (mdu_done_i && mdu_done_rd_i == REG_AW'(i))
                    sb[i] <= 1'b0;
            end
        end
    end

    assign any_flush = if_id_flush_o | id_ex_flush_o | ex_mem_flush_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (pc_stall_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (any_flush && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Directed bench for hazard_ctrl_gen: a default instance (d1) and a LU_STALL=3, WB_FWD_EN=0, CNT_W=4
// instance (d3) share one set of pipeline inputs.
module tb_hazard_ctrl_gen;

    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] BUBBLE = 8'b1100_0100;
    localparam logic [7:0] BRANCH = 8'b0000_1110;
    localparam logic [7:0] FREEZE = 8'b1111_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd, issue_rd, done_rd;
    logic use1, use2, id_rw, id_mdu, ex_rw, ex_mr, ex_nop, mem_rw, mem_nop, wb_rw;
    logic issue, done, busy, dmem, br;
    logic [1:0] pc_sel_mem;

    logic d1_pcs, d1_ifs, d1_ids, d1_exs, d1_iff, d1_idf, d1_exf, d1_wbf;
    logic d3_pcs, d3_ifs, d3_ids, d3_exs, d3_iff, d3_idf, d3_exf, d3_wbf;
    logic [1:0] d1_fa, d1_fb, d1_pc_sel, d3_fa, d3_fb, d3_pc_sel;
    logic [15:0] d1_scnt, d1_fcnt;
    logic [3:0] d3_scnt, d3_fcnt;
    logic [7:0] d1_ctrl, d3_ctrl;

    assign d1_ctrl = {d1_pcs, d1_ifs, d1_ids, d1_exs, d1_iff, d1_idf, d1_exf, d1_wbf};
    assign d3_ctrl = {d3_pcs, d3_ifs, d3_ids, d3_exs, d3_iff, d3_idf, d3_exf, d3_wbf};

    int total = 0;
    int bad = 0;

    hazard_ctrl_gen dut1 (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(id_rs1), .id_use_rs1_i(use1), .id_rs2_addr_i(id_rs2), .id_use_rs2_i(use2),
        .id_rd_addr_i(id_rd), .id_reg_write_i(id_rw), .id_is_mdu_i(id_mdu),
        .ex_rd_addr_i(ex_rd), .ex_reg_write_i(ex_rw), .ex_mem_read_i(ex_mr), .ex_is_nop_i(ex_nop),
        .mem_rd_addr_i(mem_rd), .mem_reg_write_i(mem_rw), .mem_is_nop_i(mem_nop),
        .wb_rd_addr_i(wb_rd), .wb_reg_write_i(wb_rw),
        .mdu_issue_i(issue), .mdu_issue_rd_i(issue_rd), .mdu_done_i(done), .mdu_done_rd_i(done_rd),
        .mdu_busy_i(busy), .dmem_stall_i(dmem), .branch_req_mem_i(br), .pc_sel_mem_i(pc_sel_mem),
        .pc_stall_o(d1_pcs), .if_id_stall_o(d1_ifs), .id_ex_stall_o(d1_ids), .ex_mem_stall_o(d1_exs),
        .if_id_flush_o(d1_iff), .id_ex_flush_o(d1_idf), .ex_mem_flush_o(d1_exf), .mem_wb_flush_o(d1_wbf),
        .forward_a_o(d1_fa), .forward_b_o(d1_fb), .pc_sel_o(d1_pc_sel),
        .stall_cnt_o(d1_scnt), .flush_cnt_o(d1_fcnt)
    );

    hazard_ctrl_gen #(.REG_AW(5), .LU_STALL(3), .WB_FWD_EN(0), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(id_rs1), .id_use_rs1_i(use1), .id_rs2_addr_i(id_rs2), .id_use_rs2_i(use2),
        .id_rd_addr_i(id_rd), .id_reg_write_i(id_rw), .id_is_mdu_i(id_mdu),
        .ex_rd_addr_i(ex_rd), .ex_reg_write_i(ex_rw), .ex_mem_read_i(ex_mr), .ex_is_nop_i(ex_nop),
        .mem_rd_addr_i(mem_rd), .mem_reg_write_i(mem_rw), .mem_is_nop_i(mem_nop),
        .wb_rd_addr_i(wb_rd), .wb_reg_write_i(wb_rw),
        .mdu_issue_i(issue), .mdu_issue_rd_i(issue_rd), .mdu_done_i(done), .mdu_done_rd_i(done_rd),
        .mdu_busy_i(busy), .dmem_stall_i(dmem), .branch_req_mem_i(br), .pc_sel_mem_i(pc_sel_mem),
        .pc_stall_o(d3_pcs), .if_id_stall_o(d3_ifs), .id_ex_stall_o(d3_ids), .ex_mem_stall_o(d3_exs),
        .if_id_flush_o(d3_iff), .id_ex_flush_o(d3_idf), .ex_mem_flush_o(d3_exf), .mem_wb_flush_o(d3_wbf),
        .forward_a_o(d3_fa), .forward_b_o(d3_fb), .pc_sel_o(d3_pc_sel),
        .stall_cnt_o(d3_scnt), .flush_cnt_o(d3_fcnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        issue_rd = '0; done_rd = '0; use1 = 0; use2 = 0; id_rw = 0; id_mdu = 0;
        ex_rw = 0; ex_mr = 0; ex_nop = 1; mem_rw = 0; mem_nop = 1; wb_rw = 0;
        issue = 0; done = 0; busy = 0; dmem = 0; br = 0; pc_sel_mem = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        step();
        rst = 0;
    endtask

    // LW x5 sitting in ID/EX while the ID instruction reads x5.
    task automatic set_lu_pair();
        ex_rd = 5; ex_rw = 1; ex_mr = 1; ex_nop = 0;
        id_rs1 = 5; use1 = 1; id_rs2 = 6; use2 = 1; id_rd = 8; id_rw = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst = 1;
        dmem = 1; br = 1; pc_sel_mem = 2'b11;
        ex_rd = 3; ex_rw = 1; ex_nop = 0; id_rs1 = 3; use1 = 1;
        step();
        total++; if (d1_ctrl !== NONE) begin bad++; $display("[TB] FAIL rst_ctrl_d1 got=%b exp=%b", d1_ctrl, NONE); end
        total++; if (d3_ctrl !== NONE) begin bad++; $display("[TB] FAIL rst_ctrl_d3 got=%b exp=%b", d3_ctrl, NONE); end
        total++; if (d1_pc_sel !== 2'b00) begin bad++; $display("[TB] FAIL rst_pc_sel got=%b exp=00", d1_pc_sel); end
        total++; if (d1_fa !== 2'b00) begin bad++; $display("[TB] FAIL rst_fwd_a got=%b exp=00", d1_fa); end
        total++; if (d1_scnt !== 16'd0 || d1_fcnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_cnt_d1 got=%0d/%0d exp=0/0", d1_scnt, d1_fcnt); end
        total++; if (d3_scnt !== 4'd0 || d3_fcnt !== 4'd0) begin bad++; $display("[TB] FAIL rst_cnt_d3 got=%0d/%0d exp=0/0", d3_scnt, d3_fcnt); end
        clear_inputs();
        rst = 0;
        step();
    endtask

    task automatic test_load_use();
        set_lu_pair();
        #1;
        total++; if (d1_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL lu_b1_d1 got=%b exp=%b", d1_ctrl, BUBBLE); end
        total++; if (d3_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL lu_b1_d3 got=%b exp=%b", d3_ctrl, BUBBLE); end
        total++; if (d1_fa !== 2'b01) begin bad++; $display("[TB] FAIL lu_fwd_ex got=%b exp=01", d1_fa); end
        step();
        ex_rw = 0; ex_mr = 0; ex_nop = 1; mem_rd = 5; mem_rw = 1; mem_nop = 0;
        #1;
        total++; if (d1_ctrl !== NONE) begin bad++; $display("[TB] FAIL lu_done_d1 got=%b exp=%b", d1_ctrl, NONE); end
        total++; if (d1_fa !== 2'b10) begin bad++; $display("[TB] FAIL lu_fwd_mem got=%b exp=10", d1_fa); end
        total++; if (d3_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL lu_b2_d3 got=%b exp=%b", d3_ctrl, BUBBLE); end
        step();
        mem_rw = 0; mem_nop = 1; wb_rd = 5; wb_rw = 1;
        #1;
        total++; if (d1_fa !== 2'b11) begin bad++; $display("[TB] FAIL lu_fwd_wb_d1 got=%b exp=11", d1_fa); end
        total++; if (d3_fa !== 2'b00) begin bad++; $display("[TB] FAIL lu_fwd_wb_d3 got=%b exp=00", d3_fa); end
        total++; if (d3_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL lu_b3_d3 got=%b exp=%b", d3_ctrl, BUBBLE); end
        step();
        wb_rw = 0;
        #1;
        total++; if (d3_ctrl !== NONE) begin bad++; $display("[TB] FAIL lu_end_d3 got=%b exp=%b", d3_ctrl, NONE); end
        total++; if (d1_scnt !== 16'd1 || d1_fcnt !== 16'd1) begin bad++; $display("[TB] FAIL lu_cnt_d1 got=%0d/%0d exp=1/1", d1_scnt, d1_fcnt); end
        total++; if (d3_scnt !== 4'd3 || d3_fcnt !== 4'd3) begin bad++; $display("[TB] FAIL lu_cnt_d3 got=%0d/%0d exp=3/3", d3_scnt, d3_fcnt); end
        clear_inputs();
    endtask

    task automatic test_lu_branch();
        step();
        set_lu_pair();
        #1;
        total++; if (d3_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL lub_b1 got=%b exp=%b", d3_ctrl, BUBBLE); end
        step();
        ex_rw = 0; ex_mr = 0; ex_nop = 1; br = 1; pc_sel_mem = 2'b01;
        #1;
        total++; if (d3_ctrl !== BRANCH) begin bad++; $display("[TB] FAIL lub_flush_d3 got=%b exp=%b", d3_ctrl, BRANCH); end
        total++; if (d1_ctrl !== BRANCH) begin bad++; $display("[TB] FAIL lub_flush_d1 got=%b exp=%b", d1_ctrl, BRANCH); end
        total++; if (d3_pc_sel !== 2'b01) begin bad++; $display("[TB] FAIL lub_pc_sel got=%b exp=01", d3_pc_sel); end
        step();
        br = 0; pc_sel_mem = 2'b00;
        #1;
        total++; if (d3_ctrl !== NONE) begin bad++; $display("[TB] FAIL lub_no_b3 got=%b exp=%b", d3_ctrl, NONE); end
        total++; if (d3_scnt !== 4'd4 || d3_fcnt !== 4'd5) begin bad++; $display("[TB] FAIL lub_cnt_d3 got=%0d/%0d exp=4/5", d3_scnt, d3_fcnt); end
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        step();
        issue = 1; issue_rd = 7; id_rs1 = 7; use1 = 1;
        #1;
        total++; if (d1_ctrl !== NONE) begin bad++; $display("[TB] FAIL sb_issue_cycle got=%b exp=%b", d1_ctrl, NONE); end
        step();
        issue = 0;
        #1;
        total++; if (d1_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL sb_raw got=%b exp=%b", d1_ctrl, BUBBLE); end
        step();
        done = 1; done_rd = 7;
        #1;
        total++; if (d1_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL sb_done_cycle got=%b exp=%b", d1_ctrl, BUBBLE); end
        step();
        done = 0;
        #1;
        total++; if (d1_ctrl !== NONE) begin bad++; $display("[TB] FAIL sb_cleared got=%b exp=%b", d1_ctrl, NONE); end
        step();
        issue = 1; issue_rd = 7; done = 1; done_rd = 7; use1 = 0;
        #1;
        total++; if (d1_ctrl !== NONE) begin bad++; $display("[TB] FAIL sb_same_cycle got=%b exp=%b", d1_ctrl, NONE); end
        step();
        issue = 0; done = 0; id_rd = 7; id_rw = 1;
        #1;
        total++; if (d1_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL sb_set_wins_waw got=%b exp=%b", d1_ctrl, BUBBLE); end
        step();
        done = 1; done_rd = 7; id_rw = 0; id_rs2 = 7; use2 = 1;
        #1;
        total++; if (d1_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL sb_rs2 got=%b exp=%b", d1_ctrl, BUBBLE); end
        step();
        done = 0;
        #1;
        total++; if (d1_ctrl !== NONE) begin bad++; $display("[TB] FAIL sb_cleared2 got=%b exp=%b", d1_ctrl, NONE); end
        use2 = 0; id_mdu = 1;
        #1;
        total++; if (d1_ctrl !== NONE) begin bad++; $display("[TB] FAIL sb_mdu_idle got=%b exp=%b", d1_ctrl, NONE); end
        busy = 1;
        #1;
        total++; if (d1_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL sb_mdu_busy got=%b exp=%b", d1_ctrl, BUBBLE); end
        step();
        id_mdu = 0; busy = 0; issue = 1; issue_rd = 0;
        step();
        issue = 0; id_rs1 = 0; use1 = 1;
        #1;
        total++; if (d1_ctrl !== NONE) begin bad++; $display("[TB] FAIL sb_x0 got=%b exp=%b", d1_ctrl, NONE); end
        clear_inputs();
    endtask

    task automatic test_dmem_freeze();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dmem = 1; br = 1; pc_sel_mem = 2'b10;
            #1;
            total++; if (d1_ctrl !== FREEZE) begin bad++; $display("[TB] FAIL dm_freeze%0d got=%b exp=%b", i, d1_ctrl, FREEZE); end
            total++; if (d1_pc_sel !== 2'b00) begin bad++; $display("[TB] FAIL dm_pc_sel%0d got=%b exp=00", i, d1_pc_sel); end
            step();
        end
        dmem = 0;
        #1;
        total++; if (d1_ctrl !== BRANCH) begin bad++; $display("[TB] FAIL dm_late_branch got=%b exp=%b", d1_ctrl, BRANCH); end
        total++; if (d1_pc_sel !== 2'b10) begin bad++; $display("[TB] FAIL dm_late_pc_sel got=%b exp=10", d1_pc_sel); end
        step();
        br = 0;
        #1;
        total++; if (d1_scnt !== 16'd4 || d1_fcnt !== 16'd1) begin bad++; $display("[TB] FAIL dm_cnt got=%0d/%0d exp=4/1", d1_scnt, d1_fcnt); end
        clear_inputs();
        set_lu_pair();
        #1;
        total++; if (d3_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL dm_lu_b1 got=%b exp=%b", d3_ctrl, BUBBLE); end
        step();
        ex_rw = 0; ex_mr = 0; ex_nop = 1; dmem = 1;
        #1;
        total++; if (d3_ctrl !== FREEZE) begin bad++; $display("[TB] FAIL dm_lu_freeze got=%b exp=%b", d3_ctrl, FREEZE); end
        step();
        step();
        dmem = 0;
        #1;
        total++; if (d3_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL dm_lu_b2 got=%b exp=%b", d3_ctrl, BUBBLE); end
        step();
        total++; if (d3_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL dm_lu_b3 got=%b exp=%b", d3_ctrl, BUBBLE); end
        step();
        total++; if (d3_ctrl !== NONE) begin bad++; $display("[TB] FAIL dm_lu_end got=%b exp=%b", d3_ctrl, NONE); end
        clear_inputs();
    endtask

    task automatic test_forwarding();
        step();
        id_rs1 = 3; use1 = 1; id_rs2 = 3; use2 = 1;
        ex_rd = 3; ex_rw = 1; ex_nop = 0; mem_rd = 3; mem_rw = 1; mem_nop = 0; wb_rd = 3; wb_rw = 1;
        #1;
        total++; if (d1_fa !== 2'b01 || d1_fb !== 2'b01) begin bad++; $display("[TB] FAIL fw_all got=%b/%b exp=01/01", d1_fa, d1_fb); end
        ex_rw = 0;
        #1;
        total++; if (d1_fa !== 2'b10 || d1_fb !== 2'b10) begin bad++; $display("[TB] FAIL fw_mem got=%b/%b exp=10/10", d1_fa, d1_fb); end
        ex_rw = 1; ex_nop = 1;
        #1;
        total++; if (d1_fa !== 2'b10) begin bad++; $display("[TB] FAIL fw_ex_nop got=%b exp=10", d1_fa); end
        ex_rw = 0; mem_nop = 1;
        #1;
        total++; if (d1_fa !== 2'b11) begin bad++; $display("[TB] FAIL fw_wb_d1 got=%b exp=11", d1_fa); end
        total++; if (d3_fa !== 2'b00) begin bad++; $display("[TB] FAIL fw_wb_d3 got=%b exp=00", d3_fa); end
        id_rs2 = 4;
        #1;
        total++; if (d1_fb !== 2'b00) begin bad++; $display("[TB] FAIL fw_b_nomatch got=%b exp=00", d1_fb); end
        use1 = 0;
        #1;
        total++; if (d1_fa !== 2'b00) begin bad++; $display("[TB] FAIL fw_no_use got=%b exp=00", d1_fa); end
        use1 = 1; id_rs1 = 0; ex_rd = 0; ex_rw = 1; ex_nop = 0;
        #1;
        total++; if (d1_fa !== 2'b00) begin bad++; $display("[TB] FAIL fw_x0 got=%b exp=00", d1_fa); end
        id_rs1 = 3; id_rs2 = 9; use2 = 1; ex_rd = 9; mem_rd = 3; mem_rw = 1; mem_nop = 0; wb_rw = 0;
        #1;
        total++; if (d1_fa !== 2'b10 || d1_fb !== 2'b01) begin bad++; $display("[TB] FAIL fw_mixed got=%b/%b exp=10/01", d1_fa, d1_fb); end
        clear_inputs();
    endtask

    task automatic test_saturation_reset();
        do_reset();
        id_mdu = 1; busy = 1;
        repeat (20) step();
        total++; if (d3_scnt !== 4'd15 || d3_fcnt !== 4'd15) begin bad++; $display("[TB] FAIL sat_d3 got=%0d/%0d exp=15/15", d3_scnt, d3_fcnt); end
        total++; if (d1_scnt !== 16'd20) begin bad++; $display("[TB] FAIL sat_d1 got=%0d exp=20", d1_scnt); end
        clear_inputs();
        set_lu_pair();
        step();
        ex_rw = 0; ex_mr = 0; ex_nop = 1;
        #1;
        total++; if (d3_ctrl !== BUBBLE) begin bad++; $display("[TB] FAIL rmid_wait got=%b exp=%b", d3_ctrl, BUBBLE); end
        rst = 1;
        #1;
        total++; if (d3_ctrl !== NONE) begin bad++; $display("[TB] FAIL rmid_ctrl got=%b exp=%b", d3_ctrl, NONE); end
        total++; if (d3_scnt !== 4'd0 || d3_fcnt !== 4'd0) begin bad++; $display("[TB] FAIL rmid_cnt got=%0d/%0d exp=0/0", d3_scnt, d3_fcnt); end
        step();
        rst = 0;
        #1;
        total++; if (d3_ctrl !== NONE) begin bad++; $display("[TB] FAIL rmid_idle got=%b exp=%b", d3_ctrl, NONE); end
        clear_inputs();
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_lu_branch();
        test_scoreboard();
        test_dmem_freeze();
        test_forwarding();
        test_saturation_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
